// File: rtl/store_buffer.sv
// Store buffer and load/store arbiter sitting between the CPU datapath and the
// data memory. Stores queue in a circular FIFO and retire one per cycle; loads
// own the memory bus when they miss, and hits are forwarded from the youngest
// matching queued store.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   st_ready,
  input  logic                   ld_req,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_fwd,
  output logic [DATA_W-1:0]      ld_data,
  output logic                   mem_write,
  output logic                   mem_load,
  output logic [ADDR_W-1:0]      mem_endereco,
  output logic [DATA_W-1:0]      mem_dado_escr,
  input  logic [DATA_W-1:0]      mem_dado_lido,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              push;
  logic              pop;
  logic              ldMiss;
  logic              fwdHit;
  logic [DATA_W-1:0] fwdData;
  logic [PTR_W-1:0]  scanIdx;

  // Scan valid entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    scanIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[scanIdx] == ld_addr)) begin
        fwdHit  = 1'b1;
        fwdData = data_q[scanIdx];
      end
    end
  end

  // Bus arbitration: a missing load owns the bus, otherwise the head entry drains.
  always_comb begin
    st_ready      = (count_q < CNT_W'(DEPTH));
    empty         = (count_q == '0);
    count         = count_q;
    ldMiss        = ld_req && !fwdHit;
    push          = st_valid && st_ready;
    pop           = reset && !ldMiss && (count_q != '0);
    mem_load      = reset && ldMiss;
    mem_write     = pop;
    mem_endereco  = '0;
    mem_dado_escr = '0;
    ld_fwd        = ld_req && fwdHit;
    ld_data       = '0;
    if (count_q != '0) begin
      mem_endereco  = addr_q[head_q];
      mem_dado_escr = data_q[head_q];
    end
    if (ldMiss) begin
      mem_endereco = ld_addr;
    end
    if (ld_req) begin
      ld_data = fwdHit ? fwdData : mem_dado_lido;
    end
  end

  // Pointer and occupancy next-state; simultaneous push and pop keep the count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control state with synchronous active-low reset discarding pending stores.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents beyond the valid count are never observed.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer and load/store arbiter between the CPU datapath and the 8-bit data memory. CPU stores are queued in a small FIFO and retired to memory one per cycle. CPU loads take priority on the shared memory address bus. A load whose address matches a queued store is answered from the buffer (youngest match), so the CPU never reads stale data.

## Interface
- DEPTH, 4, number of store entries (power of two, ≥2)
- ADDR_W, 8, address width
- DATA_W, 8, data width

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- st_valid  in  1  CPU store request
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_ready  out  1  buffer can accept a store (= not full)
- ld_req  in  1  CPU load request
- ld_addr  in  ADDR_W  load address
- ld_fwd  out  1  load served from buffer this cycle
- ld_data  out  DATA_W  load result (forwarded entry or mem_dado_lido)
- mem_write  out  1  write strobe to data memory
- mem_load  out  1  read enable to data memory
- mem_endereco  out  ADDR_W  memory address
- mem_dado_escr  out  DATA_W  memory write data
- mem_dado_lido  in  DATA_W  memory read data (combinational)
- empty  out  1  no pending stores
- count  out  $clog2(DEPTH)+1  pending store count

## Operation
- Circular FIFO: head pointer (oldest), tail pointer (next free), count; pointers wrap modulo DEPTH.
- Push: st_valid && st_ready → entry {st_addr, st_data} written at tail, tail++.
- Forward check: ld_req compares ld_addr against all valid entries; youngest matching entry wins. Incoming same-cycle store is not considered.
- Bus arbitration each cycle, priority order:
  - ld_req && no match → mem_load=1, mem_endereco=ld_addr, mem_write=0, ld_data=mem_dado_lido, ld_fwd=0; drain stalled.
  - otherwise, count>0 → mem_write=1, mem_endereco/mem_dado_escr = head entry; head++ at rising edge. If ld_req matched: ld_fwd=1, ld_data=matched entry.
  - otherwise all memory strobes 0; ld_data=0 when ld_req=0.
- Count update: push only +1; pop only −1; push and pop together: unchanged, both pointers advance.
- st_ready = (count < DEPTH); a push into a full buffer is refused even if a pop occurs that cycle.
- Duplicate addresses are permitted; stores retire strictly in order.

## Timing
- Memory strobes and address are combinational from FIFO state and load inputs; memory commits writes on the following falling edge. The entry retires on the next rising edge (1-cycle drain per store).
- Store-to-memory latency: minimum 1 cycle after acceptance (pushed at edge N, written at negedge of cycle N+1 if no load conflict).
- Load latency: 0 cycles (combinational result, hit or miss).
- Reset (reset=0 at rising edge): count=0, head=tail=0, pending stores discarded, no further memory write. While reset is low, mem_write and mem_load are forced to 0 combinationally so no write occurs at the negedge. After reset: st_ready=1, empty=1, count=0, ld_fwd=0, mem_write=0.
- Continuous loads starve the drain; no timeout. CPU is responsible for gaps.

## Test plan
- Reset: fill 3 stores, pull reset low one cycle → count=0, empty=1, mem_write=0 during reset, memory contents unchanged for those addresses.
- In-order drain: push (0x10,0xAA),(0x11,0xBB) back-to-back → mem_write cycles write 0x10←0xAA then 0x11←0xBB; empty=1 two cycles after last push.
- Full: push 5 stores with no drain (hold ld_req miss) → st_ready=0 after 4th, 5th not accepted, count=4; release loads → 4 writes in order.
- Forwarding: queue (0x20,0x01) then (0x20,0x02), load 0x20 → ld_fwd=1, ld_data=0x02; drain continues same cycle.
- Load miss priority: count=2, ld_req to 0x30 (mem holds 0x5C) → mem_load=1, mem_write=0, ld_data=0x5C, count stays 2.
- Push+pop same cycle with count=DEPTH−1 → count unchanged, pointers wrap correctly, data retires in order.
